// File: rtl/fir_tap_sequencer.sv
// Control sequencer for a symmetric FIR datapath. It accepts one sample, walks the
// mirrored tap address pairs, steers the MAC in step with the operand pipeline, and strobes the output register.
module fir_tap_sequencer #(
  parameter int N_TAPS      = 16,
  parameter int LOG2_N_TAPS = 4,
  parameter int PIPE_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   sample_we_o,
  output logic [LOG2_N_TAPS-1:0] addr_up_o,
  output logic [LOG2_N_TAPS-1:0] addr_down_o,
  output logic                   mac_clr_o,
  output logic                   mac_en_o,
  output logic                   out_we_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int HALF    = N_TAPS / 2;
  localparam int LAT_W   = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam int CNT_W   = (LOG2_N_TAPS > LAT_W) ? LOG2_N_TAPS : LAT_W;

  localparam logic [CNT_W-1:0]       RUN_LAST   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]       DRAIN_INIT = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [LOG2_N_TAPS-1:0] ADDR_TOP   = LOG2_N_TAPS'(N_TAPS - 1);

  if ((N_TAPS % 2) != 0) begin : g_odd_taps
    $error("fir_tap_sequencer: N_TAPS must be even");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOG2_N_TAPS-1:0] addr_up_q, addr_up_d;
  logic [LOG2_N_TAPS-1:0] addr_down_q, addr_down_d;
  logic                   sample_we_q, out_we_q, overrun_q;
  logic                   issue_d, first_d;
  // Stage 0 is the issue cycle itself; stage PIPE_LAT lines up with operands at the MAC.
  logic [PIPE_LAT:0]      issue_pipe_q, first_pipe_q;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_up_d   = addr_up_q;
    addr_down_d = addr_down_q;

    unique case (state_q)
      S_IDLE:  if (in_valid_i) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
          cnt_d   = DRAIN_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in the cycle that state is held.
    issue_d = (state_d == S_RUN);
    first_d = issue_d && (cnt_d == '0);
    if (state_d == S_LOAD) begin
      addr_up_d   = '0;
      addr_down_d = ADDR_TOP;
    end else if (issue_d) begin
      addr_up_d   = LOG2_N_TAPS'(cnt_d);
      addr_down_d = ADDR_TOP - LOG2_N_TAPS'(cnt_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_up_q    <= '0;
      addr_down_q  <= ADDR_TOP;
      sample_we_q  <= 1'b0;
      out_we_q     <= 1'b0;
      overrun_q    <= 1'b0;
      issue_pipe_q <= '0;
      first_pipe_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_up_q       <= addr_up_d;
      addr_down_q     <= addr_down_d;
      sample_we_q     <= (state_d == S_LOAD);
      out_we_q        <= (state_d == S_DONE);
      overrun_q       <= in_valid_i && (state_q != S_IDLE);
      issue_pipe_q[0] <= issue_d;
      first_pipe_q[0] <= first_d;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        issue_pipe_q[i] <= issue_pipe_q[i-1];
        first_pipe_q[i] <= first_pipe_q[i-1];
      end
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign sample_we_o = sample_we_q;
  assign addr_up_o   = addr_up_q;
  assign addr_down_o = addr_down_q;
  assign mac_en_o    = issue_pipe_q[PIPE_LAT];
  assign mac_clr_o   = first_pipe_q[PIPE_LAT];
  assign out_we_o    = out_we_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: the default configuration and a short N_TAPS=4, PIPE_LAT=0
// configuration share one stimulus stream and are compared each cycle against a timing model.
module tb_fir_tap_sequencer;

  localparam int NT [2] = '{16, 4};
  localparam int PL [2] = '{2, 0};

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        swe;
    logic        en;
    logic        clr;
    logic        owe;
    logic        ov;
    logic [31:0] up;
    logic [31:0] down;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;

  logic       rdy0, swe0, clr0, en0, owe0, busy0, ov0;
  logic [3:0] up0, dn0;
  logic       rdy1, swe1, clr1, en1, owe1, busy1, ov1;
  logic [1:0] up1, dn1;
  obs_t       obs [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc  [2];
  int eup  [2];
  int edn  [2];
  bit pov  [2];
  bit ebusy[2];

  always #5 clk = ~clk;

  fir_tap_sequencer #(.N_TAPS(16), .LOG2_N_TAPS(4), .PIPE_LAT(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy0), .sample_we_o(swe0),
    .addr_up_o(up0), .addr_down_o(dn0), .mac_clr_o(clr0), .mac_en_o(en0),
    .out_we_o(owe0), .busy_o(busy0), .overrun_o(ov0)
  );

  fir_tap_sequencer #(.N_TAPS(4), .LOG2_N_TAPS(2), .PIPE_LAT(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy1), .sample_we_o(swe1),
    .addr_up_o(up1), .addr_down_o(dn1), .mac_clr_o(clr1), .mac_en_o(en1),
    .out_we_o(owe1), .busy_o(busy1), .overrun_o(ov1)
  );

  assign obs[0] = '{ready: rdy0, busy: busy0, swe: swe0, en: en0, clr: clr0, owe: owe0,
                    ov: ov0, up: {28'd0, up0}, down: {28'd0, dn0}};
  assign obs[1] = '{ready: rdy1, busy: busy1, swe: swe1, en: en1, clr: clr1, owe: owe1,
                    ov: ov1, up: {30'd0, up1}, down: {30'd0, dn1}};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      acc[i]   = -1;
      eup[i]   = 0;
      edn[i]   = NT[i] - 1;
      pov[i]   = 1'b0;
      ebusy[i] = 1'b0;
    end
  endtask

  // Expected outputs follow from the offset o of the current cycle from the accept edge.
  task automatic check_inst(input int i);
    int  o, half, t;
    bit  busy, swe, run, en, clr, owe, ov;
    string p;
    p    = (i == 0) ? "n16" : "n4";
    half = NT[i] / 2;
    t    = half + PL[i] + 2;
    o    = (acc[i] >= 0 && !rst) ? cyc - acc[i] : -1;
    busy = (o >= 1) && (o <= t);
    swe  = (o == 1);
    run  = (o >= 2) && (o <= half + 1);
    en   = (o >= 2 + PL[i]) && (o <= half + 1 + PL[i]);
    clr  = (o == 2 + PL[i]);
    owe  = (o == t);
    ov   = pov[i] && !rst;
    if (rst || swe) begin
      eup[i] = 0;
      edn[i] = NT[i] - 1;
    end else if (run) begin
      eup[i] = o - 2;
      edn[i] = NT[i] - 1 - (o - 2);
    end
    ebusy[i] = busy;
    check({p, ".in_ready"},  32'(obs[i].ready), 32'(!busy));
    check({p, ".busy"},      32'(obs[i].busy),  32'(busy));
    check({p, ".sample_we"}, 32'(obs[i].swe),   32'(swe));
    check({p, ".addr_up"},   obs[i].up,         32'(eup[i]));
    check({p, ".addr_down"}, obs[i].down,       32'(edn[i]));
    check({p, ".mac_en"},    32'(obs[i].en),    32'(en));
    check({p, ".mac_clr"},   32'(obs[i].clr),   32'(clr));
    check({p, ".out_we"},    32'(obs[i].owe),   32'(owe));
    check({p, ".overrun"},   32'(obs[i].ov),    32'(ov));
  endtask

  // Check the cycle leading up to the next rising edge, then drive inputs for that edge.
  task automatic cycle(input bit iv, input bit r);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) check_inst(i);
    rst      = r;
    in_valid = iv;
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        pov[i] = iv && ebusy[i];
        if (iv && !ebusy[i]) acc[i] = cyc;
      end
    end
  endtask

  // Reset asserted between edges must take effect with no clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) check_inst(i);
  endtask

  initial begin
    model_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Single isolated sample.
    cycle(1'b1, 1'b0);
    repeat (16) cycle(1'b0, 1'b0);

    // in_valid held: one accept per sequence, overrun on every busy retry.
    repeat (30) cycle(1'b1, 1'b0);
    repeat (16) cycle(1'b0, 1'b0);

    // Reset in the middle of RUN, then a clean sequence.
    cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0);
    async_reset_check();
    cycle(1'b0, 1'b1);
    repeat (15) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (16) cycle(1'b0, 1'b0);

    // Reset released with in_valid already high: accepted on the first edge.
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    repeat (16) cycle(1'b0, 1'b0);

    // Random traffic with occasional synchronous-time and mid-clock resets.
    repeat (600) begin
      if ($urandom_range(0, 79) == 0) async_reset_check();
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end
    repeat (16) cycle(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
